led_output_stage: RTL and testbench
===================================

Name: led_output_stage

Overview:
- Downstream consumer of the CPU core's 8-bit output port and halt flag; drives the board LEDs.
- Detects each change on the output port and queues the new value in a small FIFO.
- Shows each queued value on the LEDs for a minimum hold time, so bursts of fast CPU writes stay visible at human speed.
- Blinks the last shown value while the core is halted and nothing is pending.

Parameters:
- DATA_WIDTH, 8, width of out_port and leds.
- FIFO_DEPTH, 4, number of queued values; power of two, at least 2.
- HOLD_CYCLES, 12500000, minimum number of clk cycles each value is displayed (0.25 s at 50 MHz); at least 1.
- BLINK_CYCLES, 25000000, clk cycles per blink phase while halted; at least 1.

Ports:
- clk  input  1  system clock (50 MHz board clock).
- rst  input  1  synchronous, active-high reset.
- out_port  input  DATA_WIDTH  CPU output port value.
- halted  input  1  CPU halted flag.
- leds  output  DATA_WIDTH  LED drive.
- busy  output  1  high while state is SHOW or the FIFO is non-empty.
- overflow  output  1  sticky; a change was dropped because the FIFO was full.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst. All state is registered on the rising edge of clk.
- Reset values:
  - leds=0, busy=0, overflow=0.
  - FIFO empty.
  - last_in=0, shown_q=0, hold_cnt=0, blink_cnt=0, blank=0.
  - FSM in IDLE.
  - Reset in any state discards queued entries and aborts the current hold or blink.
- Change detection:
  - last_in <= out_port on every cycle.
  - A push occurs at an edge where out_port != last_in; the pushed data is out_port.
  - A constant out_port produces exactly one push.
  - A non-zero out_port after reset pushes once.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - Push when full and no pop in the same cycle: data dropped, overflow <= 1 until reset.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push and pop in the same cycle when empty: impossible, because pop requires count>0 at the edge.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SHOW, HALT_BLINK.
  - IDLE, count>0: pop; shown_q <= head; hold_cnt <= HOLD_CYCLES-1; go to SHOW.
  - IDLE, count==0 and halted==1: go to HALT_BLINK; blink_cnt <= BLINK_CYCLES-1; blank <= 0.
  - SHOW, hold_cnt!=0: decrement hold_cnt.
  - SHOW, hold_cnt==0 and count>0: pop next value, reload hold_cnt, stay in SHOW (back-to-back, no gap cycle).
  - SHOW, hold_cnt==0 and count==0: go to IDLE.
  - HALT_BLINK, blink_cnt==0: blank toggles, blink_cnt reloads; otherwise blink_cnt decrements.
  - HALT_BLINK, halted==0 or count>0: go to IDLE, blank <= 0.
- Output:
  - leds = blank ? 0 : shown_q. Purely registered, no combinational path from inputs.
  - busy = (state==SHOW) | (count!=0).
- Latency: out_port changes before edge N; push at edge N; pop at edge N+1; leds shows the new value after edge N+1.
- Each value is visible for exactly HOLD_CYCLES cycles when followed by a queued value.
- halted is ignored while state is SHOW or the FIFO is non-empty; queued values always drain first.

Test Plan (HOLD_CYCLES=4, BLINK_CYCLES=3, FIFO_DEPTH=4):
1. Single value: reset, then out_port=0x5A held -> leds=0x5A from the edge after the push edge; busy high 5 cycles then 0; leds stays 0x5A.
2. Burst: 0x01, 0x02, 0x03 on consecutive cycles -> leds shows 0x01, 0x02, 0x03 for exactly 4 cycles each; overflow=0.
3. Overflow: v1..v7 distinct on consecutive cycles, v1 pushed at edge 1 -> v6 is accepted at edge 6 (simultaneous pop); v7 is dropped; overflow=1; leds sequence is v1..v6.
4. Halt blink: shown_q=0x3C, FIFO empty, halted=1 -> leds alternates 0x3C (3 cycles) / 0x00 (3 cycles); on halted=0, leds=0x3C after the next edge.
5. Reset mid-SHOW with 2 entries queued -> after the reset edge, leds=0, busy=0, overflow=0; stale entries never appear.
6. Repeat suppression: out_port held at 0x77 for 20 cycles -> exactly one push; busy low after 5 cycles.

Source files
------------

// File: rtl/led_output_stage.sv
// LED output stage: captures each change on the CPU output port into a small FIFO,
// shows every value for a minimum hold time, and blinks the last value while halted.
module led_output_stage #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int HOLD_CYCLES  = 12500000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] out_port,
    input  logic                  halted,
    output logic [DATA_WIDTH-1:0] leds,
    output logic                  busy,
    output logic                  overflow
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);

    localparam logic [CNT_W-1:0]   FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [HOLD_W-1:0]  HOLD_RELOAD   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_RELOAD  = BLINK_W'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        HALT_BLINK
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_WIDTH-1:0] last_in;
    logic [DATA_WIDTH-1:0] shown_q;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [BLINK_W-1:0]    blink_cnt;
    logic                  blank;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic fifo_empty;
    logic fifo_full;
    logic push_req;
    logic push_ok;
    logic pop;
    logic hold_done;
    logic blink_start;
    logic blink_stop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FIFO_FULL_CNT);
    assign hold_done  = (hold_cnt == '0);

    // A full FIFO can still accept a value when the head leaves in the same cycle.
    assign push_req = (out_port != last_in);
    assign push_ok  = push_req && (!fifo_full || pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of the order of the always blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_in <= '0;
        end else begin
            last_in <= out_port;
        end
    end

    // NOTE: the storage array is not reset; only pointers and count are, which
    // is enough to make stale data unreachable and keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= out_port;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every combinational output gets a default first, so no path through
    // the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = SHOW;
                end else if (halted) begin
                    next_state = HALT_BLINK;
                end
            end
            SHOW: begin
                if (hold_done && fifo_empty) begin
                    next_state = IDLE;
                end
            end
            HALT_BLINK: begin
                if (!halted || !fifo_empty) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        blink_start = 1'b0;
        blink_stop  = 1'b0;
        case (state)
            IDLE: begin
                pop         = !fifo_empty;
                blink_start = fifo_empty && halted;
            end
            SHOW: begin
                pop = hold_done && !fifo_empty;
            end
            HALT_BLINK: begin
                blink_stop = !halted || !fifo_empty;
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shown_q  <= '0;
            hold_cnt <= '0;
        end else if (pop) begin
            shown_q  <= fifo_mem[rd_ptr];
            hold_cnt <= HOLD_RELOAD;
        end else if (state == SHOW && !hold_done) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
        end
    end

    // Blink phase counter; leaving the halt state always un-blanks the display.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blank     <= 1'b0;
        end else if (blink_start) begin
            blink_cnt <= BLINK_RELOAD;
            blank     <= 1'b0;
        end else if (state == HALT_BLINK) begin
            if (blink_stop) begin
                blank <= 1'b0;
            end else if (blink_cnt == '0) begin
                blank     <= ~blank;
                blink_cnt <= BLINK_RELOAD;
            end else begin
                blink_cnt <= blink_cnt - BLINK_W'(1);
            end
        end
    end

    assign leds = blank ? '0 : shown_q;
    assign busy = (state == SHOW) || !fifo_empty;

endmodule

// File: tb/tb_led_output_stage.sv
// Scoreboard bench for led_output_stage: a queue-based reference model predicts the
// outputs after every edge; a negedge monitor compares them against the DUT.
module tb_led_output_stage;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int BLINK = 3;

    localparam int M_IDLE  = 0;
    localparam int M_SHOW  = 1;
    localparam int M_BLINK = 2;

    logic          clk;
    logic          rst;
    logic [DW-1:0] out_port;
    logic          halted;
    logic [DW-1:0] leds;
    logic          busy;
    logic          overflow;

    led_output_stage #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .HOLD_CYCLES (HOLD),
        .BLINK_CYCLES(BLINK)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .out_port(out_port),
        .halted  (halted),
        .leds    (leds),
        .busy    (busy),
        .overflow(overflow)
    );

    typedef struct {
        logic [DW-1:0] leds;
        logic          busy;
        logic          ovf;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO as a queue, hold expressed as an absolute end cycle,
    // blink phase derived from the cycles elapsed since the halt display began.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_last;
    logic [DW-1:0] m_shown;
    int            m_mode;
    int            m_show_end;
    int            m_blink_start;
    logic          m_ovf;
    int            cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [DW-1:0] o, input logic h);
        int   cnt;
        bit   do_pop;
        exp_t e;
        do_pop = 1'b0;
        if (r) begin
            m_q.delete();
            m_last  = '0;
            m_shown = '0;
            m_mode  = M_IDLE;
            m_ovf   = 1'b0;
        end else begin
            cnt = m_q.size();
            case (m_mode)
                M_IDLE: begin
                    if (cnt > 0) begin
                        do_pop = 1'b1;
                    end else if (h) begin
                        m_mode        = M_BLINK;
                        m_blink_start = cyc;
                    end
                end
                M_SHOW: begin
                    if (cyc >= m_show_end) begin
                        if (cnt > 0) do_pop = 1'b1;
                        else m_mode = M_IDLE;
                    end
                end
                default: begin
                    if (!h || cnt > 0) m_mode = M_IDLE;
                end
            endcase
            if (do_pop) begin
                m_shown    = m_q.pop_front();
                m_mode     = M_SHOW;
                m_show_end = cyc + HOLD;
            end
            if (o != m_last) begin
                if (cnt < DEPTH || do_pop) m_q.push_back(o);
                else m_ovf = 1'b1;
            end
            m_last = o;
        end
        if (m_mode == M_BLINK && (((cyc - m_blink_start) / BLINK) % 2) == 1) e.leds = '0;
        else e.leds = m_shown;
        e.busy = (m_mode == M_SHOW) || (m_q.size() != 0);
        e.ovf  = m_ovf;
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic tick(input logic r, input logic [DW-1:0] o, input logic h);
        rst      = r;
        out_port = o;
        halted   = h;
        @(posedge clk);
        model_edge(r, o, h);
        #1;
    endtask

    task automatic hold_for(input int n, input logic [DW-1:0] o, input logic h);
        for (int i = 0; i < n; i++) tick(1'b0, o, h);
    endtask

    // Monitor: one expected record per edge, compared half a cycle later.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("leds", 32'(leds), 32'(e.leds));
            check("busy", 32'(busy), 32'(e.busy));
            check("overflow", 32'(overflow), 32'(e.ovf));
        end
    end

    initial begin
        logic [DW-1:0] v;
        logic          h;
        int            drain;

        rst = 1'b1; out_port = '0; halted = 1'b0;
        tick(1'b1, 8'h00, 1'b0);
        tick(1'b1, 8'h00, 1'b0);
        check("reset_leds", 32'(leds), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_overflow", 32'(overflow), 32'h0);

        // Single value: shown for good, busy drops after five cycles.
        hold_for(10, 8'h5A, 1'b0);
        check("single_leds", 32'(leds), 32'h5A);
        check("single_busy", 32'(busy), 32'h0);

        // Burst of three consecutive writes.
        tick(1'b0, 8'h01, 1'b0);
        tick(1'b0, 8'h02, 1'b0);
        hold_for(16, 8'h03, 1'b0);
        check("burst_leds", 32'(leds), 32'h03);
        check("burst_overflow", 32'(overflow), 32'h0);

        // Overflow: seven distinct writes, the seventh is dropped.
        for (int i = 1; i <= 6; i++) tick(1'b0, 8'(8'h10 + i), 1'b0);
        hold_for(30, 8'h17, 1'b0);
        check("ovf_sticky", 32'(overflow), 32'h1);
        check("ovf_last_shown", 32'(leds), 32'h16);
        tick(1'b1, 8'h00, 1'b0);

        // Halt blink on 0x3C, then release.
        hold_for(10, 8'h3C, 1'b0);
        hold_for(14, 8'h3C, 1'b1);
        tick(1'b0, 8'h3C, 1'b0);
        check("unhalt_leds", 32'(leds), 32'h3C);

        // Reset while showing with two entries queued.
        tick(1'b0, 8'hA1, 1'b0);
        tick(1'b0, 8'hA2, 1'b0);
        tick(1'b0, 8'hA3, 1'b0);
        tick(1'b1, 8'h00, 1'b0);
        check("midshow_rst_leds", 32'(leds), 32'h0);
        check("midshow_rst_busy", 32'(busy), 32'h0);
        check("midshow_rst_overflow", 32'(overflow), 32'h0);
        hold_for(12, 8'h00, 1'b0);
        check("no_stale_leds", 32'(leds), 32'h0);

        // Repeat suppression.
        hold_for(20, 8'h77, 1'b0);
        check("repeat_busy", 32'(busy), 32'h0);
        check("repeat_leds", 32'(leds), 32'h77);

        // Randomized traffic: bursts, constant runs, halts and occasional resets.
        v = 8'h00;
        h = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) v = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) h = ~h;
            if ($urandom_range(0, 99) == 0) tick(1'b1, v, h);
            else if ($urandom_range(0, 3) == 0) hold_for(int'($urandom_range(1, 12)), v, h);
            else tick(1'b0, v, h);
        end

        drain = 0;
        while (exp_q.size() > 0 && drain < 5) begin
            @(negedge clk);
            drain++;
        end
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
